play_cmd_scheduler: RTL and testbench

//  Upstream feeder for game_top's play port. Buffers action commands from two

---
 rtl/game_pkg.sv | 35 +++
 rtl/cmd_fifo.sv | 61 ++++++
 rtl/play_cmd_scheduler.sv | 156 +++++++++++++++
 tb/tb_play_cmd_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game encodings: actions, phase, winner and scheduler FSM states.
package game_pkg;

  localparam int unsigned ACT_W = 3;

  typedef enum logic [ACT_W-1:0] {
    ACT_KICK  = 3'd0,
    ACT_PUNCH = 3'd1,
    ACT_LEFT  = 3'd2,
    ACT_RIGHT = 3'd3,
    ACT_WAIT  = 3'd4
  } action_e;

  localparam logic [ACT_W-1:0] ACT_MAX = 3'd4;

  localparam logic PHASE_PLAY = 1'b0;
  localparam logic PHASE_SHOP = 1'b1;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_ISSUE = 2'd2,
    S_GAP   = 2'd3
  } sched_state_e;

  // Codes 5..7 are not actions and must be dropped at the FIFO input.
  function automatic logic act_is_legal(input logic [ACT_W-1:0] a);
    return a <= ACT_MAX;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with flush; level is one bit wider than the pointers.
module cmd_fifo #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over any same-cycle push or pop.
  assign do_push = push & ~full  & ~flush;
  assign do_pop  = pop  & ~empty & ~flush;

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign dout  = mem[rd_ptr];

  // Pointers and level; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents are don't-care while empty so no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/play_cmd_scheduler.sv
// Buffers per-player commands and issues round-robin play strobes to game_top.
module play_cmd_scheduler
  import game_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       phase,
  input  logic [1:0]                 winner,
  input  logic                       cmd_valid_p1,
  input  logic [ACT_W-1:0]           cmd_action_p1,
  output logic                       cmd_ready_p1,
  input  logic                       cmd_valid_p2,
  input  logic [ACT_W-1:0]           cmd_action_p2,
  output logic                       cmd_ready_p2,
  output logic                       play_valid,
  output logic                       turn,
  output logic [ACT_W-1:0]           play_action,
  output logic                       err_bad_cmd_p1,
  output logic                       err_bad_cmd_p2,
  output logic [$clog2(DEPTH):0]     level_p1,
  output logic [$clog2(DEPTH):0]     level_p2
);

  localparam int unsigned CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_turn_q, last_turn_d;
  logic             play_valid_d;
  logic             turn_d;
  logic [ACT_W-1:0] action_d;

  logic             full_p1, empty_p1, full_p2, empty_p2;
  logic [ACT_W-1:0] head_p1, head_p2;
  logic             push_p1, push_p2, pop_p1, pop_p2;
  logic             round_end, flush;
  logic             pref, pref_ne, alt_ne, sel, have_pick;

  // Round ends on SHOP or any winner; only flushes once a round is running.
  assign round_end = (phase == PHASE_SHOP) || (winner != WIN_NONE);
  assign flush     = (state_q != S_IDLE) && round_end;

  assign cmd_ready_p1 = ~full_p1;
  assign cmd_ready_p2 = ~full_p2;

  assign push_p1 = cmd_valid_p1 & ~full_p1 & act_is_legal(cmd_action_p1) & ~flush;
  assign push_p2 = cmd_valid_p2 & ~full_p2 & act_is_legal(cmd_action_p2) & ~flush;

  // Round-robin pick: prefer the player not served last, else repeat.
  assign pref      = ~last_turn_q;
  assign pref_ne   = pref ? ~empty_p2 : ~empty_p1;
  assign alt_ne    = pref ? ~empty_p1 : ~empty_p2;
  assign sel       = pref_ne ? pref : last_turn_q;
  assign have_pick = pref_ne | alt_ne;

  cmd_fifo #(.WIDTH(ACT_W), .DEPTH(DEPTH)) u_fifo_p1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push_p1),
    .pop   (pop_p1),
    .flush (flush),
    .din   (cmd_action_p1),
    .dout  (head_p1),
    .level (level_p1),
    .full  (full_p1),
    .empty (empty_p1)
  );

  cmd_fifo #(.WIDTH(ACT_W), .DEPTH(DEPTH)) u_fifo_p2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push_p2),
    .pop   (pop_p2),
    .flush (flush),
    .din   (cmd_action_p2),
    .dout  (head_p2),
    .level (level_p2),
    .full  (full_p2),
    .empty (empty_p2)
  );

  // Next-state, pop and registered-output targets for the issue FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_turn_d  = last_turn_q;
    play_valid_d = 1'b0;
    turn_d       = turn;
    action_d     = play_action;
    pop_p1       = 1'b0;
    pop_p2       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!round_end) state_d = S_ARB;
      end
      S_ARB: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (have_pick) begin
          pop_p1       = ~sel;
          pop_p2       = sel;
          turn_d       = sel;
          action_d     = sel ? head_p2 : head_p1;
          play_valid_d = 1'b1;
          last_turn_d  = sel;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_ARB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter, arbitration history and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      last_turn_q    <= 1'b1;
      play_valid     <= 1'b0;
      turn           <= 1'b0;
      play_action    <= '0;
      err_bad_cmd_p1 <= 1'b0;
      err_bad_cmd_p2 <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      last_turn_q    <= last_turn_d;
      play_valid     <= play_valid_d;
      turn           <= turn_d;
      play_action    <= action_d;
      err_bad_cmd_p1 <= cmd_valid_p1 & ~act_is_legal(cmd_action_p1);
      err_bad_cmd_p2 <= cmd_valid_p2 & ~act_is_legal(cmd_action_p2);
    end
  end

endmodule

// File: tb/tb_play_cmd_scheduler.sv
// Directed bench for play_cmd_scheduler (DEPTH=4, GAP_CYCLES=1).
module tb_play_cmd_scheduler;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned GAP_CYCLES = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       phase;
  logic [1:0] winner;
  logic       cmd_valid_p1, cmd_valid_p2;
  logic [2:0] cmd_action_p1, cmd_action_p2;
  logic       cmd_ready_p1, cmd_ready_p2;
  logic       play_valid, turn;
  logic [2:0] play_action;
  logic       err_bad_cmd_p1, err_bad_cmd_p2;
  logic [2:0] level_p1, level_p2;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_cyc    = 0;
  bit have_last   = 1'b0;

  play_cmd_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk            (clk),
    .rst            (rst),
    .phase          (phase),
    .winner         (winner),
    .cmd_valid_p1   (cmd_valid_p1),
    .cmd_action_p1  (cmd_action_p1),
    .cmd_ready_p1   (cmd_ready_p1),
    .cmd_valid_p2   (cmd_valid_p2),
    .cmd_action_p2  (cmd_action_p2),
    .cmd_ready_p2   (cmd_ready_p2),
    .play_valid     (play_valid),
    .turn           (turn),
    .play_action    (play_action),
    .err_bad_cmd_p1 (err_bad_cmd_p1),
    .err_bad_cmd_p2 (err_bad_cmd_p2),
    .level_p1       (level_p1),
    .level_p2       (level_p2)
  );

  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a strobe, check its payload, spacing and 1-cycle width.
  task automatic expect_issue(input logic t, input logic [2:0] a, input string tag);
    int n = 0;
    while (play_valid !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_strobe"}, 8'(play_valid), 8'd1);
    chk({tag, "_turn"}, 8'(turn), 8'(t));
    chk({tag, "_action"}, 8'(play_action), 8'(a));
    if (have_last) begin
      vectors++;
      assert (cyc - last_cyc >= int'(GAP_CYCLES) + 2) else begin
        miscompares++;
        $error("FAIL %s_spacing: observed %0d, expected >= %0d", tag, cyc - last_cyc,
               GAP_CYCLES + 2);
      end
    end
    last_cyc  = cyc;
    have_last = 1'b1;
    step();
    chk({tag, "_width"}, 8'(play_valid), 8'd0);
  endtask

  initial begin
    logic seen;
    rst = 1'b1; phase = 1'b0; winner = 2'b00;
    cmd_valid_p1 = 1'b0; cmd_action_p1 = 3'd0;
    cmd_valid_p2 = 1'b0; cmd_action_p2 = 3'd0;
    #1;
    chk("rst_play_valid", 8'(play_valid), 8'd0);
    chk("rst_turn", 8'(turn), 8'd0);
    chk("rst_action", 8'(play_action), 8'd0);
    chk("rst_level_p1", 8'(level_p1), 8'd0);
    chk("rst_level_p2", 8'(level_p2), 8'd0);
    chk("rst_err", 8'({err_bad_cmd_p1, err_bad_cmd_p2}), 8'd0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: P1 {3,3}, P2 {2}; P1 served first, then alternation.
    cmd_valid_p1 = 1'b1; cmd_action_p1 = 3'd3;
    cmd_valid_p2 = 1'b1; cmd_action_p2 = 3'd2;
    step();
    cmd_valid_p2 = 1'b0;
    chk("t1_level_p1", 8'(level_p1), 8'd1);
    chk("t1_level_p2", 8'(level_p2), 8'd1);
    chk("t1_no_early_strobe", 8'(play_valid), 8'd0);
    step();
    cmd_valid_p1 = 1'b0;
    chk("t1_latency", 8'(play_valid), 8'd1);
    chk("t1_pushpop_level", 8'(level_p1), 8'd1);
    expect_issue(1'b0, 3'd3, "t1_a");
    expect_issue(1'b1, 3'd2, "t1_b");
    expect_issue(1'b0, 3'd3, "t1_c");
    chk("t1_drained", 8'({level_p1, level_p2}), 8'd0);

    // 2: preload during SHOP, 5th beat refused when full.
    phase = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      cmd_valid_p1 = 1'b1; cmd_action_p1 = 3'(i);
      if (i == 4) chk("t2_ready_full", 8'(cmd_ready_p1), 8'd0);
      step();
    end
    cmd_valid_p1 = 1'b0;
    chk("t2_level_full", 8'(level_p1), 8'd4);
    chk("t2_no_err_full", 8'(err_bad_cmd_p1), 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen |= play_valid;
    end
    chk("t2_no_issue_shop", 8'(seen), 8'd0);
    phase = 1'b0;
    have_last = 1'b0;
    expect_issue(1'b0, 3'd0, "t2_a");
    expect_issue(1'b0, 3'd1, "t2_b");
    expect_issue(1'b0, 3'd2, "t2_c");
    expect_issue(1'b0, 3'd3, "t2_d");
    chk("t2_drained", 8'(level_p1), 8'd0);

    // 3: illegal code on P2 is dropped with a one-cycle error pulse.
    cmd_valid_p2 = 1'b1; cmd_action_p2 = 3'd6;
    step();
    cmd_valid_p2 = 1'b0;
    chk("t3_err_pulse", 8'(err_bad_cmd_p2), 8'd1);
    chk("t3_level_p2", 8'(level_p2), 8'd0);
    step();
    chk("t3_err_clear", 8'(err_bad_cmd_p2), 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen |= play_valid;
    end
    chk("t3_no_issue", 8'(seen), 8'd0);

    // 4: winner mid-round flushes queued commands.
    phase = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      cmd_valid_p1 = 1'b1; cmd_action_p1 = 3'd1;
      step();
    end
    cmd_valid_p1 = 1'b0;
    phase = 1'b0;
    have_last = 1'b0;
    expect_issue(1'b0, 3'd1, "t4_a");
    chk("t4_level_before", 8'(level_p1), 8'd2);
    winner = 2'b01;
    step();
    chk("t4_flush_p1", 8'(level_p1), 8'd0);
    chk("t4_flush_p2", 8'(level_p2), 8'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= play_valid;
    end
    chk("t4_no_more_issue", 8'(seen), 8'd0);

    // 5: only P2 queued, served back to back with the gap.
    winner = 2'b00; phase = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cmd_valid_p2 = 1'b1; cmd_action_p2 = 3'd2;
      step();
    end
    cmd_valid_p2 = 1'b0;
    phase = 1'b0;
    have_last = 1'b0;
    expect_issue(1'b1, 3'd2, "t5_a");
    expect_issue(1'b1, 3'd2, "t5_b");
    expect_issue(1'b1, 3'd2, "t5_c");

    // 6: async reset during GAP clears everything without a clock edge.
    phase = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      cmd_valid_p1 = 1'b1; cmd_action_p1 = 3'd4;
      cmd_valid_p2 = 1'b1; cmd_action_p2 = 3'd3;
      step();
    end
    cmd_valid_p1 = 1'b0; cmd_valid_p2 = 1'b0;
    phase = 1'b0;
    have_last = 1'b0;
    expect_issue(1'b0, 3'd4, "t6_a");
    expect_issue(1'b1, 3'd3, "t6_b");
    chk("t6_pre_levels", 8'({level_p1, level_p2}), 8'({3'd1, 3'd1}));
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 8'(play_valid), 8'd0);
    chk("t6_async_turn", 8'(turn), 8'd0);
    chk("t6_async_action", 8'(play_action), 8'd0);
    chk("t6_async_levels", 8'({level_p1, level_p2}), 8'd0);
    step();
    rst = 1'b0;
    have_last = 1'b0;
    cmd_valid_p1 = 1'b1; cmd_action_p1 = 3'd0;
    cmd_valid_p2 = 1'b1; cmd_action_p2 = 3'd1;
    step();
    cmd_valid_p1 = 1'b0; cmd_valid_p2 = 1'b0;
    expect_issue(1'b0, 3'd0, "t6_c");
    expect_issue(1'b1, 3'd1, "t6_d");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
